// File: rtl/dm9000a_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm9000a_pkg
// Brief    : Shared FSM state encoding and counter sizing for dm9000a_bus_ctrl.
// Revision : 1.0
// ============================================================================
package dm9000a_pkg;

    typedef enum logic [2:0] {
        ST_CHIPRST = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_HOLD    = 3'd4
    } dm_state_e;

    // One spare bit so a terminal count of exactly 2**n still fits.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm9000a_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dm9000a_bus_ctrl_if
// Brief    : Host-side request/response bundle of the DM9000A bus controller.
// Revision : 1.0
// ============================================================================
interface dm9000a_bus_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              iREQ;
    logic              iWE;
    logic              iCMD;
    logic [DATA_W-1:0] iDATA;
    logic              iSOFT_RST;
    logic [DATA_W-1:0] oDATA;
    logic              oACK;
    logic              oBUSY;
    logic              oINT;

    modport master (
        output iREQ, iWE, iCMD, iDATA, iSOFT_RST,
        input  oDATA, oACK, oBUSY, oINT
    );

    modport slave (
        input  iREQ, iWE, iCMD, iDATA, iSOFT_RST,
        output oDATA, oACK, oBUSY, oINT
    );
endinterface
`default_nettype wire

// File: rtl/dm9000a_int_sync.sv
`default_nettype none
// ============================================================================
// Module   : dm9000a_int_sync
// Brief    : STAGES-deep flop chain for bringing asynchronous board inputs in.
// Revision : 1.0
// ============================================================================
module dm9000a_int_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    if (STAGES < 1) begin : g_bad_stages
        $error("dm9000a_int_sync: STAGES must be >= 1");
    end

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/dm9000a_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm9000a_bus_ctrl
// Brief    : Host-request to DM9000A strobe sequencer with chip reset and INT sync.
// Revision : 1.0
// ============================================================================
module dm9000a_bus_ctrl
    import dm9000a_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int SETUP_CYC       = 1,
    parameter int STROBE_CYC      = 2,
    parameter int HOLD_CYC        = 1,
    parameter int CLK_DIV         = 1,
    parameter int RST_CYC         = 4,
    parameter int INT_SYNC_STAGES = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    dm9000a_bus_ctrl_if.slave host,
    output logic              ENET_CLK,
    output logic              ENET_CMD,
    output logic              ENET_CS_N,
    output logic              ENET_RD_N,
    output logic              ENET_WR_N,
    output logic              ENET_RST_N,
    inout  wire  [DATA_W-1:0] ENET_DATA,
    input  logic              ENET_INT
);
    if (DATA_W != 8 && DATA_W != 16) begin : g_bad_data_w
        $error("dm9000a_bus_ctrl: DATA_W must be 8 or 16");
    end
    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
        $error("dm9000a_bus_ctrl: SETUP_CYC/STROBE_CYC/HOLD_CYC must be >= 1");
    end
    if (CLK_DIV < 1 || RST_CYC < 1) begin : g_bad_clk_rst
        $error("dm9000a_bus_ctrl: CLK_DIV/RST_CYC must be >= 1");
    end
    if (INT_SYNC_STAGES < 2) begin : g_bad_sync
        $error("dm9000a_bus_ctrl: INT_SYNC_STAGES must be >= 2");
    end

    localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;

    localparam logic [2:0] S_CHIPRST = ST_CHIPRST;
    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_SETUP   = ST_SETUP;
    localparam logic [2:0] S_STROBE  = ST_STROBE;
    localparam logic [2:0] S_HOLD    = ST_HOLD;

    logic [2:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_pend, w_pend_nxt;
    logic              w_accept, w_we_eff, w_cmd_eff, w_txn_nxt;
    logic              r_we, r_cmd_l;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              r_ack, r_busy, r_int, r_oe;
    logic              r_cs_n, r_rd_n, r_wr_n, r_cmd, r_rst_n, r_clk;
    logic [DIV_W-1:0]  r_div;
    logic              w_sync_q;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_pend_nxt  = r_pend;
        w_accept    = 1'b0;
        case (r_state)
            S_CHIPRST: begin
                if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_IDLE: begin
                w_cnt_nxt = '0;
                // A soft reset (fresh or deferred) outranks a pending request.
                if (host.iSOFT_RST || r_pend) begin
                    w_state_nxt = S_CHIPRST;
                    w_pend_nxt  = 1'b0;
                end else if (host.iREQ) begin
                    w_state_nxt = S_SETUP;
                    w_accept    = 1'b1;
                end
            end
            S_SETUP: begin
                if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = '0;
                end
            end
            S_STROBE: begin
                if (r_cnt == CNT_W'(STROBE_CYC - 1)) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CHIPRST;
                w_cnt_nxt   = '0;
            end
        endcase
        if (host.iSOFT_RST && (r_state == S_SETUP || r_state == S_STROBE || r_state == S_HOLD)) begin
            w_pend_nxt = 1'b1;
        end
    end

    // Pin outputs are decoded from the next state so they are flop outputs.
    assign w_txn_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) || (w_state_nxt == S_HOLD);
    assign w_we_eff  = w_accept ? host.iWE  : r_we;
    assign w_cmd_eff = w_accept ? host.iCMD : r_cmd_l;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_CHIPRST;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_we    <= 1'b0;
            r_cmd_l <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b1;
            r_int   <= 1'b0;
            r_oe    <= 1'b0;
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_cmd   <= 1'b0;
            r_rst_n <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            if (w_accept) begin
                r_we    <= host.iWE;
                r_cmd_l <= host.iCMD;
                r_wdata <= host.iDATA;
            end
            if (r_state == S_STROBE && w_state_nxt == S_HOLD && !r_we) begin
                r_rdata <= ENET_DATA;
            end
            r_ack   <= (r_state == S_HOLD) && (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_int   <= w_sync_q && (w_state_nxt != S_CHIPRST);
            r_oe    <= w_txn_nxt && w_we_eff;
            r_cs_n  <= !w_txn_nxt;
            r_rd_n  <= !((w_state_nxt == S_STROBE) && !w_we_eff);
            r_wr_n  <= !((w_state_nxt == S_STROBE) && w_we_eff);
            r_cmd   <= w_txn_nxt && w_cmd_eff;
            r_rst_n <= (w_state_nxt != S_CHIPRST);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_div <= '0;
            r_clk <= 1'b0;
        end else if (r_div == DIV_W'(CLK_DIV - 1)) begin
            r_div <= '0;
            r_clk <= ~r_clk;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // The final synchroniser stage lives in r_int so CHIPRST can gate it.
    dm9000a_int_sync #(
        .STAGES (INT_SYNC_STAGES - 1)
    ) u_int_sync (
        .i_clk (iCLK),
        .i_rst (iRST),
        .i_d   (ENET_INT),
        .o_q   (w_sync_q)
    );

    assign ENET_DATA  = r_oe ? r_wdata : {DATA_W{1'bz}};
    assign ENET_CLK   = r_clk;
    assign ENET_CMD   = r_cmd;
    assign ENET_CS_N  = r_cs_n;
    assign ENET_RD_N  = r_rd_n;
    assign ENET_WR_N  = r_wr_n;
    assign ENET_RST_N = r_rst_n;
    assign host.oDATA = r_rdata;
    assign host.oACK  = r_ack;
    assign host.oBUSY = r_busy;
    assign host.oINT  = r_int;
endmodule
`default_nettype wire

// File: tb/tb_dm9000a_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm9000a_bus_ctrl
// Brief    : Randomised and directed bench for dm9000a_bus_ctrl against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_dm9000a_bus_ctrl;
    localparam int DW = 16, S = 1, W = 2, H = 1, CD = 1, RC = 4, IS = 2;
    localparam int P = S + W + H + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm9000a_bus_ctrl_if #(.DATA_W(DW)) hif();
    wire  [DW-1:0] enet_data;
    logic          chip_en  = 1'b1;
    logic [DW-1:0] chip_val = '0;
    logic enet_clk, enet_cmd, cs_n, rd_n, wr_n, rst_n;
    logic enet_int = 1'b0;
    assign enet_data = chip_en ? chip_val : {DW{1'bz}};

    dm9000a_bus_ctrl #(
        .DATA_W(DW), .SETUP_CYC(S), .STROBE_CYC(W), .HOLD_CYC(H),
        .CLK_DIV(CD), .RST_CYC(RC), .INT_SYNC_STAGES(IS)
    ) dut (
        .iCLK(clk), .iRST(rst), .host(hif.slave),
        .ENET_CLK(enet_clk), .ENET_CMD(enet_cmd), .ENET_CS_N(cs_n),
        .ENET_RD_N(rd_n), .ENET_WR_N(wr_n), .ENET_RST_N(rst_n),
        .ENET_DATA(enet_data), .ENET_INT(enet_int)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Timeline model: a transaction accepted in cycle acc_t occupies acc_t+1..acc_t+P-1
    // and acknowledges in acc_t+P; a chip reset occupies cycles up to rst_end.
    int n = 0, acc_t = -1, rst_end = 0, clk_base = 0, ph = 0;
    bit m_we, m_cmd, pend;
    logic [DW-1:0] m_wdata = '0, last_rd = '0;
    bit e_txn, e_ack, e_rst = 1'b1, e_drive;
    bit int_d1, int_d2;

    bit k_rand = 0, k_req = 0, k_we = 0, k_cmd = 0, k_srst = 0, k_int = 0, k_fix = 0;
    logic [DW-1:0] k_data = '0, k_fixv = '0;

    initial begin
        hif.iREQ = 0; hif.iWE = 0; hif.iCMD = 0; hif.iDATA = '0; hif.iSOFT_RST = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            int_d2 = int_d1;
            int_d1 = enet_int;
            if (rst) begin
                acc_t = -1; pend = 0; last_rd = '0; int_d1 = 0; int_d2 = 0;
                e_txn = 0; e_ack = 0; e_rst = 1; e_drive = 0; ph = 0;
            end else begin
                ph      = n - acc_t;
                e_txn   = (acc_t >= 0) && (ph >= 1) && (ph <= P - 1);
                e_ack   = (acc_t >= 0) && (ph == P);
                e_rst   = (n <= rst_end);
                e_drive = e_txn && m_we;
            end
            chip_en  = !e_drive;
            chip_val = k_fix ? k_fixv : DW'($urandom);
            if (!rst && e_txn && !m_we && ph == S + W) last_rd = chip_val;
            if (k_rand) begin
                hif.iREQ      = ($urandom_range(0, 2) != 0);
                hif.iWE       = $urandom_range(0, 1) != 0;
                hif.iCMD      = $urandom_range(0, 1) != 0;
                hif.iDATA     = DW'($urandom);
                hif.iSOFT_RST = ($urandom_range(0, 30) == 0);
                if ($urandom_range(0, 7) == 0) enet_int = ~enet_int;
            end else begin
                hif.iREQ = k_req; hif.iWE = k_we; hif.iCMD = k_cmd;
                hif.iDATA = k_data; hif.iSOFT_RST = k_srst; enet_int = k_int;
            end
            if (!rst) begin
                if (!(e_rst || e_txn)) begin
                    if (hif.iSOFT_RST || pend) begin
                        rst_end = n + RC;
                        pend    = 0;
                    end else if (hif.iREQ) begin
                        acc_t = n; m_we = hif.iWE; m_cmd = hif.iCMD; m_wdata = hif.iDATA;
                    end
                end else if (e_txn && hif.iSOFT_RST) begin
                    pend = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_cs_n", cs_n, 1); chk("rst_rd_n", rd_n, 1); chk("rst_wr_n", wr_n, 1);
            chk("rst_cmd", enet_cmd, 0); chk("rst_rst_n", rst_n, 0); chk("rst_clk", enet_clk, 0);
            chk("rst_odata", hif.oDATA, 0); chk("rst_ack", hif.oACK, 0);
            chk("rst_busy", hif.oBUSY, 1); chk("rst_int", hif.oINT, 0);
            chk("rst_bus", enet_data, chip_val);
        end else begin
            chk("cs_n", cs_n, !e_txn);
            chk("wr_n", wr_n, !(e_txn && m_we && ph > S && ph <= S + W));
            chk("rd_n", rd_n, !(e_txn && !m_we && ph > S && ph <= S + W));
            chk("busy", hif.oBUSY, e_rst || e_txn);
            chk("ack", hif.oACK, e_ack);
            chk("rst_n", rst_n, !e_rst);
            chk("enet_clk", enet_clk, ((n - clk_base) / CD) % 2);
            chk("oint", hif.oINT, !e_rst && int_d2);
            if (e_txn) chk("cmd", enet_cmd, m_cmd);
            else       chk("odata", hif.oDATA, last_rd);
            chk("bus", enet_data, e_drive ? m_wdata : chip_val);
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (hif.oBUSY && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (hif.oBUSY) begin
            n_chk++; n_err++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
    endtask

    task automatic quiet();
        k_rand = 0; k_req = 0; k_srst = 0;
        repeat (20) @(negedge clk);
        wait_idle();
    endtask

    // Issue one request from a negedge; returns at the negedge of the acceptance cycle.
    task automatic issue(input bit we, input bit cmd, input logic [DW-1:0] d);
        k_we = we; k_cmd = cmd; k_data = d; k_req = 1;
        @(negedge clk);
        k_req = 0;
    endtask

    task automatic release_rst();
        @(posedge clk); #3;
        rst = 0; rst_end = n + RC - 1; clk_base = n;
    endtask

    int acks;
    logic [31:0] mask;

    initial begin
        repeat (3) @(negedge clk);
        release_rst();
        @(negedge clk);
        @(negedge clk); chk("pu_clk1", enet_clk, 1);
        @(negedge clk); chk("pu_clk2", enet_clk, 0);
        @(negedge clk); chk("pu_rstn3", rst_n, 0); chk("pu_busy3", hif.oBUSY, 1);
        @(negedge clk); chk("pu_rstn4", rst_n, 1); chk("pu_busy4", hif.oBUSY, 0);

        quiet();
        issue(1, 1, 16'hA5C3);
        @(negedge clk); chk("w_cs1", cs_n, 0); chk("w_data1", enet_data, 16'hA5C3);
                        chk("w_cmd1", enet_cmd, 1); chk("w_wr1", wr_n, 1);
        @(negedge clk); chk("w_wr2", wr_n, 0);
        @(negedge clk); chk("w_wr3", wr_n, 0);
        @(negedge clk); chk("w_cs4", cs_n, 0); chk("w_wr4", wr_n, 1); chk("w_data4", enet_data, 16'hA5C3);
        @(negedge clk); chk("w_ack5", hif.oACK, 1); chk("w_cs5", cs_n, 1);

        quiet();
        k_fix = 1; k_fixv = 16'h1234;
        issue(0, 0, 16'h0);
        @(negedge clk); chk("r_rd1", rd_n, 1); chk("r_cmd1", enet_cmd, 0);
        @(negedge clk); chk("r_rd2", rd_n, 0);
        @(negedge clk); chk("r_rd3", rd_n, 0);
        @(negedge clk);
        @(negedge clk); chk("r_ack5", hif.oACK, 1); chk("r_data5", hif.oDATA, 16'h1234);
        k_fix = 0;

        quiet();
        k_we = 1; k_cmd = 1; k_data = 16'h5EED; k_req = 1;
        acks = 0; mask = '0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i == 10) k_req = 0;
            if (hif.oACK) begin acks++; mask[i] = 1'b1; end
        end
        chk("b2b_count", acks, 3);
        chk("b2b_pos", mask, 32'h0000_8420);

        k_int = 1;
        quiet();
        issue(1, 0, 16'h0F0F);
        @(negedge clk); k_srst = 1;
        @(negedge clk); k_srst = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); chk("sr_ack5", hif.oACK, 1); chk("sr_int5", hif.oINT, 1);
        @(negedge clk); chk("sr_rstn6", rst_n, 0); chk("sr_int6", hif.oINT, 0);
        repeat (3) @(negedge clk);
        chk("sr_rstn9", rst_n, 0); chk("sr_int9", hif.oINT, 0);
        @(negedge clk); chk("sr_rstn10", rst_n, 1); chk("sr_int10", hif.oINT, 1);
        chk("sr_busy10", hif.oBUSY, 0);

        quiet();
        k_we = 1; k_cmd = 0; k_data = 16'h3C3C; k_req = 1; k_srst = 1;
        @(negedge clk); k_srst = 0;
        @(negedge clk); chk("sq_cs1", cs_n, 1); chk("sq_rstn1", rst_n, 0);
        repeat (3) @(negedge clk);
        chk("sq_rstn4", rst_n, 0);
        @(negedge clk); chk("sq_rstn5", rst_n, 1); chk("sq_busy5", hif.oBUSY, 0); chk("sq_cs5", cs_n, 1);
        k_req = 0;
        @(negedge clk); chk("sq_cs6", cs_n, 0);

        k_int = 0;
        quiet();
        k_int = 1;
        @(negedge clk); chk("int0", hif.oINT, 0);
        @(negedge clk); chk("int1", hif.oINT, 0);
        @(negedge clk); chk("int2", hif.oINT, 1);

        k_rand = 1;
        repeat (2500) @(negedge clk);

        quiet();
        issue(1, 1, 16'hAA55);
        @(negedge clk);
        @(negedge clk); chk("ab_wr_pre", wr_n, 0);
        @(posedge clk); #3;
        rst = 1; chip_en = 1; chip_val = 16'h5A3C;
        #1;
        chk("ab_cs", cs_n, 1); chk("ab_wr", wr_n, 1); chk("ab_bus", enet_data, 16'h5A3C);
        chk("ab_ack", hif.oACK, 0);
        repeat (3) @(negedge clk);
        release_rst();

        k_rand = 1;
        repeat (1500) @(negedge clk);
        quiet();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dm9000a_bus_ctrl.md
Name: dm9000a_bus_ctrl

Overview:
Parametrised timing engine between the internal host bus and a DM9000A-class Ethernet MAC/PHY.
- Turns single-word host requests into CS/CMD/RD/WR strobe sequences with programmable setup, strobe and hold cycles.
- Sequences the chip's hardware reset at power-up and on software command, generates ENET_CLK, and synchronises the chip interrupt.
- Sits between the SOPC host-bus slave and the board Ethernet pins.

Parameters:
DATA_W, 16, data bus width (8 or 16)
SETUP_CYC, 1, cycles CS_N/CMD (and write data) are valid before the strobe falls (>=1)
STROBE_CYC, 2, cycles RD_N/WR_N are held low (>=1)
HOLD_CYC, 1, cycles CS_N/CMD/write data are held after the strobe rises (>=1)
CLK_DIV, 1, iCLK cycles per ENET_CLK half-period (>=1)
RST_CYC, 4, cycles ENET_RST_N is held low per chip reset (>=1)
INT_SYNC_STAGES, 2, synchroniser depth for ENET_INT (>=2)

Ports:
iCLK  in  1  system clock
iRST  in  1  asynchronous, active-high reset
iREQ  in  1  transaction request (level); sampled only while oBUSY=0
iWE  in  1  1=write, 0=read; sampled with iREQ
iCMD  in  1  value driven on ENET_CMD (0=index, 1=data); sampled with iREQ
iDATA  in  DATA_W  write data; sampled with iREQ
iSOFT_RST  in  1  single-cycle pulse requesting a chip reset
oDATA  out  DATA_W  read data; valid from oACK, held until the next read completes
oACK  out  1  one-cycle completion pulse
oBUSY  out  1  high whenever the FSM is not in IDLE
oINT  out  1  synchronised chip interrupt
ENET_CLK  out  1  divided clock to the chip
ENET_CMD  out  1  command/data select
ENET_CS_N  out  1  chip select, active low
ENET_RD_N  out  1  read strobe, active low
ENET_WR_N  out  1  write strobe, active low
ENET_RST_N  out  1  chip reset, active low
ENET_DATA  inout  DATA_W  bidirectional data bus
ENET_INT  in  1  asynchronous chip interrupt

Behaviour:
- Reset values while iRST=1:
  - ENET_CS_N=1, ENET_RD_N=1, ENET_WR_N=1, ENET_CMD=0.
  - ENET_RST_N=0, ENET_CLK=0, ENET_DATA=Z.
  - oDATA=0, oACK=0, oBUSY=1, oINT=0.
  - FSM is held in CHIPRST with its cycle counter cleared.
- All outputs are registered. iRST asserted mid-transaction aborts it immediately: outputs and bus go to the reset values asynchronously.
- FSM states and transitions:
  - CHIPRST: ENET_RST_N=0, all strobes inactive. Exit to IDLE after RST_CYC cycles.
  - IDLE: oBUSY=0. If iSOFT_RST=1, go to CHIPRST. Otherwise, if iREQ=1, latch iWE/iCMD/iDATA and go to SETUP.
  - SETUP: ENET_CS_N=0, ENET_CMD=latched cmd. Lasts SETUP_CYC cycles, then STROBE.
  - STROBE: ENET_RD_N=0 (read) or ENET_WR_N=0 (write). Lasts STROBE_CYC cycles. On reads, ENET_DATA is captured into oDATA on the last STROBE cycle. Then HOLD.
  - HOLD: strobes high, CS_N and CMD still asserted. Lasts HOLD_CYC cycles, then IDLE with oACK=1 for that one cycle.
- ENET_DATA is driven with the latched data only for writes, in SETUP, STROBE and HOLD; it is Z otherwise.
- Timing with the request accepted in cycle t:
  - CS_N is low for t+1 .. t+S+W+H, where S=SETUP_CYC, W=STROBE_CYC, H=HOLD_CYC.
  - oACK is high in cycle t+S+W+H+1.
  - A new iREQ may be accepted in that same oACK cycle. Back-to-back period is S+W+H+1 cycles (5 at defaults).
- iREQ is ignored while oBUSY=1. The requester deasserts or changes iREQ after oACK.
- iSOFT_RST handling:
  - Asserted outside IDLE: latched as pending. The current transaction completes (oACK still pulses), then the FSM enters CHIPRST.
  - iSOFT_RST and iREQ together in IDLE: the soft reset wins and the request is not accepted; a still-held iREQ is accepted after CHIPRST.
- ENET_CLK is free-running and toggles every CLK_DIV iCLK cycles, starting from 0 after iRST release. It is independent of the FSM.
- oINT is ENET_INT passed through INT_SYNC_STAGES flops (latency INT_SYNC_STAGES cycles). It is forced to 0 while in CHIPRST.
- Counter widths are sized with $clog2 of the largest of SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC, plus 1.
- Parameters violating their minimums are an elaboration error.

Decomposition:
- Package dm9000a_pkg: FSM state enum (CHIPRST, IDLE, SETUP, STROBE, HOLD) and the counter-width function.
- Sub-module dm9000a_int_sync: parametrised INT_SYNC_STAGES synchroniser with async active-high reset, also used for other board inputs.

Test Plan:
- Power-up: release iRST -> ENET_RST_N=0 and oBUSY=1 for exactly 4 cycles, then IDLE with oBUSY=0; ENET_CLK toggles every cycle.
- Write: iREQ=1, iWE=1, iCMD=1, iDATA=0xA5C3 accepted at t -> CS_N=0 t+1..t+4, WR_N=0 t+2..t+3, ENET_DATA=0xA5C3 t+1..t+4 then Z, ENET_CMD=1, oACK at t+5.
- Read: chip model drives 0x1234, iWE=0, iCMD=0 -> RD_N=0 t+2..t+3, oDATA=0x1234 with oACK at t+5, ENET_DATA never driven by the DUT.
- Back-to-back: iREQ held for 3 writes -> acceptances exactly 5 cycles apart, 3 oACK pulses.
- Soft reset: iSOFT_RST pulse during STROBE -> transaction completes with oACK, then ENET_RST_N low 4 cycles and oINT=0 throughout. iSOFT_RST+iREQ in the same IDLE cycle -> reset first, request accepted afterwards.
- Interrupt/abort: ENET_INT rises -> oINT rises 2 cycles later. iRST asserted mid-write -> CS_N/WR_N=1 and ENET_DATA=Z immediately, no oACK.
